// File: rtl/flags_stack_register_if.sv
// Bus bundle for the flags stack register: write/stack controls in, flags and status out.
interface flags_stack_register_if #(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
    logic              write_en;
    logic [FLAG_W-1:0] write_mask;
    logic              sticky_en;
    logic [FLAG_W-1:0] in_flags;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [FLAG_W-1:0] out_flags;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output write_en, write_mask, sticky_en, in_flags, push, pop, err_clr,
        input  out_flags, count, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  write_en, write_mask, sticky_en, in_flags, push, pop, err_clr,
        output out_flags, count, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/flags_stack_register.sv
// Live ALU flag register with per-bit load/sticky writes and a small save/restore stack.
// Pop beats the write path; push+pop together cancel on the stack and only the write applies.
module flags_stack_register #(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    flags_stack_register_if.slave  bus
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] live_q, live_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [FLAG_W-1:0] stack_q [DEPTH];

    logic              full, empty;
    logic              push_ok, pop_ok;
    logic              ovf_set, unf_set;
    logic [FLAG_W-1:0] wr_bits, wr_val;
    logic [CNT_W-1:0]  cnt_m1;
    logic [IdxW-1:0]   push_idx, pop_idx;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Decode stack operations, errors and the next live/count/error state.
    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        wr_bits  = '0;
        wr_val   = '0;
        cnt_m1   = count_q - CNT_W'(1);
        push_idx = count_q[IdxW-1:0];
        pop_idx  = cnt_m1[IdxW-1:0];
        live_d   = live_q;
        count_d  = count_q;

        // Simultaneous push and pop is a no-op on the stack.
        if (bus.push && !bus.pop) begin
            push_ok = !full;
            ovf_set = full;
        end
        if (bus.pop && !bus.push) begin
            pop_ok  = !empty;
            unf_set = empty;
        end

        wr_bits = bus.write_en ? bus.write_mask : '0;
        wr_val  = bus.sticky_en ? (live_q | bus.in_flags) : bus.in_flags;

        if (pop_ok) begin
            live_d  = stack_q[pop_idx];
            count_d = cnt_m1;
        end else begin
            live_d = (live_q & ~wr_bits) | (wr_val & wr_bits);
            if (push_ok) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // A new error event outranks a clear in the same cycle.
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
        unf_d = (unf_q & ~bus.err_clr) | unf_set;
    end

    // Live flags, occupancy and sticky errors; cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; entries at or above count are never read, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[push_idx] <= live_q;
        end
    end

    assign bus.out_flags = live_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf_err   = ovf_q;
    assign bus.unf_err   = unf_q;
endmodule

// File: tb/tb_flags_stack_register.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_flags_stack_register;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    flags_stack_register_if #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    flags_stack_register #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: live flags, a queue as the stack, two sticky error bits.
    logic [FLAG_W-1:0] m_live;
    logic [FLAG_W-1:0] m_stack[$];
    bit                m_ovf;
    bit                m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " out_flags"}, 32'(bus.out_flags), 32'(m_live));
        check({tag, " count"},     32'(bus.count),     32'(m_stack.size()));
        check({tag, " full"},      32'(bus.full),      32'(m_stack.size() == int'(DEPTH)));
        check({tag, " empty"},     32'(bus.empty),     32'(m_stack.size() == 0));
        check({tag, " ovf_err"},   32'(bus.ovf_err),   32'(m_ovf));
        check({tag, " unf_err"},   32'(bus.unf_err),   32'(m_unf));
    endtask

    task automatic model_reset();
        m_live = '0;
        m_stack.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic drive(input bit we, input logic [FLAG_W-1:0] mask, input bit sticky,
                         input logic [FLAG_W-1:0] in, input bit push, input bit pop,
                         input bit clr);
        bus.write_en   = we;
        bus.write_mask = mask;
        bus.sticky_en  = sticky;
        bus.in_flags   = in;
        bus.push       = push;
        bus.pop        = pop;
        bus.err_clr    = clr;
    endtask

    // Drive one cycle, advance the model by the stated rules, then compare after the edge.
    task automatic cycle(input string tag, input bit we, input logic [FLAG_W-1:0] mask,
                         input bit sticky, input logic [FLAG_W-1:0] in, input bit push,
                         input bit pop, input bit clr);
        logic [FLAG_W-1:0] old;
        bit ovf_ev, unf_ev;
        drive(we, mask, sticky, in, push, pop, clr);
        old    = m_live;
        ovf_ev = push && !pop && (m_stack.size() == int'(DEPTH));
        unf_ev = pop && !push && (m_stack.size() == 0);
        if (pop && !push && m_stack.size() > 0) begin
            m_live = m_stack.pop_back();
        end else begin
            for (int i = 0; i < int'(FLAG_W); i++) begin
                if (we && mask[i]) m_live[i] = sticky ? (old[i] | in[i]) : in[i];
            end
            if (push && !pop && m_stack.size() < int'(DEPTH)) m_stack.push_back(old);
        end
        m_ovf = (m_ovf && !clr) || ovf_ev;
        m_unf = (m_unf && !clr) || unf_ev;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input string tag, input logic [FLAG_W-1:0] v);
        cycle(tag, 1'b1, 4'hf, 1'b0, v, 1'b0, 1'b0, 1'b0);
    endtask

    logic [FLAG_W-1:0] first_pushed;

    initial begin
        // Reset held low with busy inputs: nothing may change, even across edges.
        reset = 1'b0;
        drive(1'b1, 4'hf, 1'b0, 4'hf, 1'b1, 1'b0, 1'b0);
        model_reset();
        #2;
        check_all("reset async");
        @(posedge clk);
        #1;
        check_all("reset held");
        check("reset empty const", 32'(bus.empty), 32'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Load mode.
        load("load a", 4'b1010);
        check("load a const", 32'(bus.out_flags), 32'b1010);
        cycle("load masked", 1'b1, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
        check("load masked const", 32'(bus.out_flags), 32'b1001);
        cycle("mask w/o en", 1'b0, 4'hf, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);

        // Sticky mode.
        load("clear", 4'b0000);
        cycle("sticky a", 1'b1, 4'hf, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        cycle("sticky b", 1'b1, 4'hf, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        check("sticky b const", 32'(bus.out_flags), 32'b1001);
        load("sticky off", 4'b0000);
        check("sticky off const", 32'(bus.out_flags), 32'b0000);

        // Push with a concurrent write, then pop restores the pre-push value.
        load("pre push", 4'b0110);
        cycle("push+write", 1'b1, 4'hf, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        check("push+write out", 32'(bus.out_flags), 32'b1111);
        check("push+write cnt", 32'(bus.count), 32'd1);
        cycle("pop+write", 1'b1, 4'hf, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("pop restore", 32'(bus.out_flags), 32'b0110);
        check("pop empty", 32'(bus.empty), 32'd1);

        // Overflow and underflow.
        load("first", 4'b0011);
        first_pushed = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            cycle("ovf push", 1'b1, 4'hf, 1'b0, 4'($urandom), 1'b1, 1'b0, 1'b0);
        end
        check("ovf count", 32'(bus.count), 32'd4);
        check("ovf full", 32'(bus.full), 32'd1);
        check("ovf err", 32'(bus.ovf_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle("unf pop", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("unf count", 32'(bus.count), 32'd0);
        check("unf err", 32'(bus.unf_err), 32'd1);
        check("unf restore", 32'(bus.out_flags), 32'(first_pushed));
        cycle("err clr", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("err clr ovf", 32'(bus.ovf_err), 32'd0);
        check("err clr unf", 32'(bus.unf_err), 32'd0);

        // Simultaneous events.
        cycle("sim push1", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle("sim push2", 1'b1, 4'hf, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0);
        cycle("push+pop", 1'b1, 4'b1100, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
        check("push+pop cnt", 32'(bus.count), 32'd2);
        check("push+pop ovf", 32'(bus.ovf_err), 32'd0);
        check("push+pop unf", 32'(bus.unf_err), 32'd0);
        cycle("drain1", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle("drain2", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle("pop empty wr", 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        cycle("clr+pop empty", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("clr+pop unf", 32'(bus.unf_err), 32'd1);
        cycle("clr alone", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges with work in flight.
        for (int i = 0; i < 3; i++) begin
            cycle("fill3", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        load("set f", 4'b1111);
        check("pre rst cnt", 32'(bus.count), 32'd3);
        drive(1'b1, 4'hf, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst out", 32'(bus.out_flags), 32'd0);
        check("arst count", 32'(bus.count), 32'd0);
        check("arst empty", 32'(bus.empty), 32'd1);
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst held");
        reset = 1'b1;
        load("post rst", 4'b1100);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flags_stack_register.md
FLAGS_STACK_REGISTER -- requirements
Module: flags_stack_register

Interface
REQ-001 Parameter FLAG_W, default 4, number of flag bits; for 4, bit order is {N,Z,C,O} with N at bit 3 and O at bit 0.
REQ-002 Parameter DEPTH, default 4, number of save/restore stack entries; legal range is 2..16.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 write_en  input  1  flag write enable, the C14 control.
REQ-007 write_mask  input  FLAG_W  per-bit write enable; it is qualified by write_en.
REQ-008 sticky_en  input  1  mode select: 0 = load, 1 = OR-accumulate.
REQ-009 in_flags  input  FLAG_W  ALU-generated flag values.
REQ-010 push  input  1  save the live flags onto the stack.
REQ-011 pop  input  1  restore the live flags from the stack top.
REQ-012 err_clr  input  1  clears the sticky error bits.
REQ-013 out_flags  output  FLAG_W  live flag register, sent to control logic.
REQ-014 count  output  CNT_W  number of occupied stack entries.
REQ-015 full / empty  output  1 each  high when count == DEPTH / count == 0.
REQ-016 ovf_err / unf_err  output  1 each  sticky push-when-full / pop-when-empty error flags.

Function
REQ-017 Write, load mode: for each bit i with write_en and write_mask[i] high, the module SHALL set live[i] <= in_flags[i].
REQ-018 Write, sticky mode: under the same bit qualification, the module SHALL set live[i] <= live[i] | in_flags[i].
REQ-019 Bits not written SHALL hold their value.
REQ-020 Write latency SHALL be 1 cycle: out_flags shows the new value after the edge.
REQ-021 A push with !full SHALL store the pre-edge live value in entry[count] and increment count.
REQ-022 A write in the same cycle as a push SHALL still update live, so the stack holds the old value and live holds the new one.
REQ-023 A pop with !empty SHALL set live <= entry[count-1] and decrement count.
REQ-024 A write in the same cycle as a pop SHALL be ignored, because the pop has priority.
REQ-025 When push and pop are asserted together, count and the entries SHALL be unchanged, live SHALL take the write path only, and no error bit SHALL be set.
REQ-026 A push while full SHALL leave the stack and count unchanged and set ovf_err; the write path still applies.
REQ-027 A pop while empty SHALL leave live and count unchanged and set unf_err; the write path still applies.
REQ-028 ovf_err and unf_err SHALL remain set until an err_clr cycle.
REQ-029 If err_clr coincides with a new error event, the error bit SHALL end the cycle set, so the set wins.
REQ-030 count SHALL never exceed DEPTH and SHALL never wrap below 0.
REQ-031 full and empty SHALL be combinational decodes of the registered count.
REQ-032 Entries at or above count SHALL be don't-care and never observable at any output.

Reset
REQ-033 While reset is low, regardless of clk, the module SHALL drive out_flags = 0, count = 0, empty = 1, full = 0, ovf_err = 0 and unf_err = 0.
REQ-034 Stack entry contents need not be cleared on reset.
REQ-035 Reset asserted mid-operation SHALL discard any push, pop or write in progress.
REQ-036 The first edge after reset deasserts SHALL process inputs normally.

Verification
REQ-037 Load mode: write_en=1, mask=4'b1111, in=4'b1010, then write_en=1, mask=4'b0011, in=4'b0101 -> out_flags=1010 then 1001.
REQ-038 Sticky mode: sticky_en=1, mask=1111, in=0001, then in=1000 -> out_flags=0001 then 1001; a load of 0000 with sticky_en=0 then gives 0000.
REQ-039 Push and write together: live=0110, push=1 with write in=1111 -> out=1111 and count=1; a following pop -> out=0110, count=0, empty=1.
REQ-040 Overflow and underflow at DEPTH=4:
- 5 pushes -> count=4, full=1, ovf_err=1.
- 5 pops -> count=0, unf_err=1, out_flags equal to the first pushed value.
- err_clr -> both error bits = 0.
REQ-041 Simultaneous events: push+pop with count=2 -> count stays 2, no error; err_clr with a pop when empty -> unf_err=1.
REQ-042 Asynchronous reset: assert reset low between clock edges with count=3 and out=1111 -> out=0000, count=0 and empty=1 immediately, with no clock edge needed.
